// File: rtl/rtc_lector_secuencia.sv
// RTC read sequencer: reads eleven registers over the multiplexed A/D bus into a
// local buffer, then replays them to the display interface as one timed burst.
module rtc_lector_secuencia #(
  parameter int unsigned T_PULSE = 7,
  parameter int unsigned T_GAP   = 3,
  parameter int unsigned LEAD    = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d,
  output logic       inicioSecuencia,
  output logic [7:0] datoRTC,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StGapA, StData, StGapD, StLead, StStream
  } state_e;

  localparam logic [3:0] PulseLast  = 4'(T_PULSE - 1);
  localparam logic [3:0] GapLast    = 4'(T_GAP - 1);
  localparam logic [3:0] LeadLast   = 4'(LEAD - 1);
  localparam logic [3:0] IdxLast    = 4'd10;

  function automatic logic [7:0] rtc_addr(input logic [3:0] i);
    logic [7:0] a;
    unique case (i)
      4'd0:    a = 8'h21;
      4'd1:    a = 8'h22;
      4'd2:    a = 8'h23;
      4'd3:    a = 8'h24;
      4'd4:    a = 8'h25;
      4'd5:    a = 8'h26;
      4'd6:    a = 8'h27;
      4'd7:    a = 8'h28;
      4'd8:    a = 8'h41;
      4'd9:    a = 8'h42;
      default: a = 8'h43;
    endcase
    return a;
  endfunction

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] rd_buf_q [0:10];
  logic [7:0] rd_buf_d [0:10];

  logic [7:0] ad_out_q, ad_out_d;
  logic       ad_oe_q, ad_oe_d;
  logic       cs_n_q, cs_n_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic       a_d_q, a_d_d;
  logic       inicio_q, inicio_d;
  logic [7:0] dato_q, dato_d;
  logic       busy_q, busy_d;

  // Sequencer next state: phase counter, register index and buffer capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 4'd1;
    idx_d    = idx_q;
    rd_buf_d = rd_buf_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        // busy_q still high on the first IDLE clock: a tick there is dropped.
        if (tick && !busy_q) begin
          state_d = StAddr;
          idx_d   = '0;
        end
      end
      StAddr: if (cnt_q == PulseLast) begin
        state_d = StGapA;
        cnt_d   = '0;
      end
      StGapA: if (cnt_q == GapLast) begin
        state_d = StData;
        cnt_d   = '0;
      end
      StData: if (cnt_q == PulseLast) begin
        state_d = StGapD;
        cnt_d   = '0;
      end
      StGapD: begin
        // Pins lag the state by one clock, so the last rd_n-low clock is here.
        if (cnt_q == 4'd0) rd_buf_d[idx_q] = ad_in;
        if (cnt_q == GapLast) begin
          cnt_d = '0;
          if (idx_q == IdxLast) begin
            state_d = StLead;
          end else begin
            state_d = StAddr;
            idx_d   = idx_q + 4'd1;
          end
        end
      end
      StLead: if (cnt_q == LeadLast) begin
        state_d = StStream;
        cnt_d   = '0;
      end
      StStream: if (cnt_q == IdxLast) begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Pin values decoded from the current state; registered on the next edge.
  always_comb begin
    ad_out_d = '0;
    ad_oe_d  = 1'b0;
    cs_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    a_d_d    = 1'b1;
    inicio_d = 1'b0;
    dato_d   = '0;
    busy_d   = (state_q != StIdle);
    unique case (state_q)
      StAddr: begin
        a_d_d    = 1'b0;
        cs_n_d   = 1'b0;
        wr_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = rtc_addr(idx_q);
      end
      StData: begin
        cs_n_d = 1'b0;
        rd_n_d = 1'b0;
      end
      StLead:   inicio_d = 1'b1;
      StStream: begin
        inicio_d = 1'b1;
        dato_d   = rd_buf_q[cnt_q];
      end
      default: ;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      for (int i = 0; i < 11; i++) rd_buf_q[i] <= '0;
      ad_out_q <= '0;
      ad_oe_q  <= 1'b0;
      cs_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      a_d_q    <= 1'b1;
      inicio_q <= 1'b0;
      dato_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      rd_buf_q <= rd_buf_d;
      ad_out_q <= ad_out_d;
      ad_oe_q  <= ad_oe_d;
      cs_n_q   <= cs_n_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      a_d_q    <= a_d_d;
      inicio_q <= inicio_d;
      dato_q   <= dato_d;
      busy_q   <= busy_d;
    end
  end

  assign ad_out          = ad_out_q;
  assign ad_oe           = ad_oe_q;
  assign cs_n            = cs_n_q;
  assign rd_n            = rd_n_q;
  assign wr_n            = wr_n_q;
  assign a_d             = a_d_q;
  assign inicioSecuencia = inicio_q;
  assign datoRTC         = dato_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_rtc_lector_secuencia.sv
// Bench for rtc_lector_secuencia: two instances (default and short timing) against
// a timeline model of the read-and-replay transaction, plus literal timing checks.
module tb_rtc_lector_secuencia;

  localparam int TPv [2] = '{7, 2};
  localparam int TGv [2] = '{3, 1};
  localparam int LDv [2] = '{10, 3};
  localparam logic [7:0] ADDRS [11] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
                                        8'h27, 8'h28, 8'h41, 8'h42, 8'h43};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic [7:0] lat [2];
  logic [7:0] ad_in0, ad_in1, aout0, aout1, dato0, dato1;
  logic oe0, oe1, cs0, cs1, rd0, rd1, wr0, wr1, ad0, ad1, ini0, ini1, busy0, busy1;
  logic [22:0] act [2];

  assign ad_in0 = mem[lat[0]];
  assign ad_in1 = mem[lat[1]];
  assign act[0] = {busy0, ini0, dato0, cs0, rd0, wr0, oe0, ad0, aout0};
  assign act[1] = {busy1, ini1, dato1, cs1, rd1, wr1, oe1, ad1, aout1};

  rtc_lector_secuencia u_dut0 (
    .clk(clk), .reset(reset), .tick(tick), .ad_in(ad_in0), .ad_out(aout0), .ad_oe(oe0),
    .cs_n(cs0), .rd_n(rd0), .wr_n(wr0), .a_d(ad0), .inicioSecuencia(ini0),
    .datoRTC(dato0), .busy(busy0)
  );

  rtc_lector_secuencia #(.T_PULSE(2), .T_GAP(1), .LEAD(3)) u_dut1 (
    .clk(clk), .reset(reset), .tick(tick), .ad_in(ad_in1), .ad_out(aout1), .ad_oe(oe1),
    .cs_n(cs1), .rd_n(rd1), .wr_n(wr1), .a_d(ad1), .inicioSecuencia(ini1),
    .datoRTC(dato1), .busy(busy1)
  );

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int mt [2] = '{-1, -1};
  int acc [2] = '{0, 0};
  int rise [2] = '{0, 0};
  int width [2] = '{0, 0};
  int nrise [2] = '{0, 0};
  int wrf [2] = '{0, 0};
  int bfall [2] = '{0, 0};
  int brise [2] = '{0, 0};
  logic [7:0] first_byte [2];
  logic [7:0] last_byte [2];
  logic [22:0] prev [2];

  function automatic int total_len(input int i);
    return 11 * 2 * (TPv[i] + TGv[i]) + LDv[i] + 12;
  endfunction

  // Expected pins t clocks after the accepting edge; m masks don't-care bits.
  function automatic void model_at(input int i, input int t, output logic [22:0] e,
                                   output logic [22:0] m);
    int p, u, r, ph, s;
    e = {1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
    m = '1;
    p = 2 * (TPv[i] + TGv[i]);
    if (t > 0 && t < total_len(i)) begin
      e[22] = 1'b1;
      m[8] = 1'b0;
      m[7:0] = 8'h00;
      if (t <= 11 * p) begin
        u = t - 1;
        r = u / p;
        ph = u % p;
        if (ph < TPv[i]) begin
          e[12] = 1'b0; e[10] = 1'b0; e[9] = 1'b1; e[8] = 1'b0;
          m[8] = 1'b1; m[7:0] = 8'hff; e[7:0] = ADDRS[r];
        end else if (ph >= TPv[i] + TGv[i] && ph < 2 * TPv[i] + TGv[i]) begin
          e[12] = 1'b0; e[11] = 1'b0; e[8] = 1'b1; m[8] = 1'b1;
        end
      end else begin
        s = t - 11 * p - 1;
        e[21] = 1'b1;
        if (s >= LDv[i]) e[20:13] = mem[ADDRS[s - LDv[i]]];
      end
    end
  endfunction

  // Transaction model and RTC bus model, advanced on the active edge.
  always @(posedge clk or posedge reset) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        mt[i] <= -1;
      end else if (tick && (mt[i] < 0 || mt[i] >= total_len(i))) begin
        mt[i] <= 0;
        acc[i] <= cyc + 1;
      end else if (mt[i] >= 0 && mt[i] < total_len(i)) begin
        mt[i] <= mt[i] + 1;
      end
      if (!act[i][12] && !act[i][10] && act[i][9]) lat[i] <= act[i][7:0];
    end
  end

  // Per-cycle comparison against the model, plus edge monitors.
  always @(negedge clk) begin
    logic [22:0] e, m;
    for (int i = 0; i < 2; i++) begin
      model_at(i, mt[i], e, m);
      n_checks++;
      if (((act[i] ^ e) & m) != 23'd0)
        $display("FAIL dut%0d pins t=%0d: got %h want %h (mask %h)", i, mt[i], act[i], e, m);
      else n_pass++;
      if (act[i][21] && !prev[i][21]) begin rise[i] = cyc; nrise[i]++; end
      if (!act[i][21] && prev[i][21]) width[i] = cyc - rise[i];
      if (act[i][21] && cyc == rise[i] + LDv[i]) first_byte[i] = act[i][20:13];
      if (act[i][21] && cyc == rise[i] + LDv[i] + 10) last_byte[i] = act[i][20:13];
      if (!act[i][10] && prev[i][10]) wrf[i]++;
      if (!act[i][22] && prev[i][22]) bfall[i] = cyc;
      if (act[i][22] && !prev[i][22]) brise[i] = cyc;
      prev[i] = act[i];
    end
  end

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) $display("FAIL %s: got %0d want %0d", name, got, want);
    else n_pass++;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    do begin
      @(negedge clk);
      n++;
    end while ((busy0 || busy1) && n < max);
    check("wait_idle in budget", int'(n < max), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k, w0, w1, r0, r1;
    for (int a = 0; a < 256; a++) mem[a] = 8'(a + 1);
    lat[0] = 8'h00;
    lat[1] = 8'h00;
    prev[0] = act[0];
    prev[1] = act[1];
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle for 1000 clocks: per-cycle compare expects reset values throughout.
    repeat (1000) @(posedge clk);
    #1;
    check("idle no burst", nrise[0] + nrise[1], 0);

    // Bus returns address+1.
    w0 = wrf[0]; w1 = wrf[1];
    pulse_tick();
    k = cyc;
    wait_idle(400);
    check("d0 tick to inicio rise", rise[0] - k, 221);
    check("d0 tick to busy fall", bfall[0] - k, 242);
    check("d0 inicio width", width[0], 21);
    check("d0 address cycles", wrf[0] - w0, 11);
    check("d0 first byte", first_byte[0], 8'h22);
    check("d0 last byte", last_byte[0], 8'h44);
    check("d1 tick to inicio rise", rise[1] - k, 67);
    check("d1 inicio width", width[1], 14);
    check("d1 tick to busy fall", bfall[1] - k, 81);
    check("d1 address cycles", wrf[1] - w1, 11);
    check("d1 first byte", first_byte[1], 8'h22);

    // Realistic BCD contents.
    mem[8'h21] = 8'h24; mem[8'h22] = 8'h01; mem[8'h23] = 8'h01; mem[8'h24] = 8'h23;
    mem[8'h25] = 8'h12; mem[8'h26] = 8'h17; mem[8'h27] = 8'h05; mem[8'h28] = 8'h01;
    mem[8'h41] = 8'h27; mem[8'h42] = 8'h08; mem[8'h43] = 8'h09;
    pulse_tick();
    wait_idle(400);
    check("bcd first byte", first_byte[0], 8'h24);
    check("bcd last byte", last_byte[0], 8'h09);

    // Second tick on the 50th busy clock is dropped.
    w0 = wrf[0]; r0 = nrise[0]; r1 = nrise[1];
    pulse_tick();
    k = cyc;
    repeat (49) @(posedge clk);
    #1;
    pulse_tick();
    wait_idle(400);
    check("ignored tick busy span", bfall[0] - k, 242);
    check("ignored tick one burst d0", nrise[0] - r0, 1);
    check("ignored tick one burst d1", nrise[1] - r1, 1);
    check("ignored tick address cycles", wrf[0] - w0, 11);

    // Reset during the data phase of index 4.
    pulse_tick();
    k = cyc;
    repeat (93) @(posedge clk);
    #1;
    check("in data phase before reset", {31'd0, rd0}, 0);
    reset = 1'b1;
    #1;
    check("reset strobes high", {29'd0, cs0, rd0, wr0}, 7);
    check("reset oe low", {31'd0, oe0}, 0);
    check("reset inicio and busy", {30'd0, ini0, busy0}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    r0 = nrise[0];
    repeat (300) @(posedge clk);
    #1;
    check("no burst after reset", nrise[0] - r0, 0);
    pulse_tick();
    k = cyc;
    wait_idle(400);
    check("post-reset busy span", bfall[0] - k, 242);
    check("post-reset inicio width", width[0], 21);
    check("post-reset first byte", first_byte[0], 8'h24);

    // Tick held across the clock busy falls and the first idle clock.
    pulse_tick();
    k = cyc;
    repeat (241) @(posedge clk);
    #1 tick = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 tick = 1'b0;
    check("model accepts first idle clock", acc[0] - k, 243);
    wait_idle(400);
    check("late tick busy rise", brise[0] - k, 244);
    check("late tick busy span", bfall[0] - k, 243 + 242);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
